// File: rtl/ifetch_prefetch_queue_if.sv
// Signal bundle between the fetch front end, the instruction memory and decode.
// Handshake: an entry transfers on a rising edge where out_valid and out_ready are both high;
// out_valid never waits on out_ready, and out_pc/out_inst hold steady while out_valid is high without out_ready.
interface ifetch_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     fetch_en;
  logic [31:0]              imem_addr;
  logic [31:0]              imem_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [31:0]              out_inst;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic [$clog2(DEPTH):0]   q_count;

  // Fetch unit side.
  modport master (
    input  fetch_en, imem_data, out_ready, redirect_valid, redirect_pc,
    output imem_addr, out_valid, out_pc, out_inst, q_count
  );

  // Core / memory side.
  modport slave (
    output fetch_en, imem_data, out_ready, redirect_valid, redirect_pc,
    input  imem_addr, out_valid, out_pc, out_inst, q_count
  );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// Sequential instruction prefetcher: walks fetch_pc, buffers {pc, inst} pairs in a
// small circular queue for decode, and flushes/restarts on a redirect.
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  ifetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic valid;
  logic pop;
  logic push;

  assign valid = (count_q != '0);
  assign pop   = valid & bus.out_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push  = bus.fetch_en & ~bus.redirect_valid & ((count_q < FULL_CNT) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      // Flush discards everything, including a head decode tried to take this cycle.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= bus.imem_data;
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
  assign bus.out_inst  = valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign bus.q_count   = count_q;
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Randomized and directed bench for ifetch_prefetch_queue, checked against a
// queue-based reference model of the fetch front end.
module tb_ifetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

  logic clk;
  logic rst;

  ifetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  ifetch_prefetch_queue #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational instruction memory.
  assign bus.imem_data = bus.imem_addr ^ IMEM_KEY;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch PC plus an ordered list of buffered entries.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_known;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    check("imem_addr", bus.imem_addr, m_pc);
    check("q_count", 32'(bus.q_count), 32'(m_q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check("out_pc", bus.out_pc, head[63:32]);
      check("out_inst", bus.out_inst, head[31:0]);
    end else begin
      check("out_pc_empty", bus.out_pc, 32'h0);
      check("out_inst_empty", bus.out_inst, NOP_INST);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic rdy,
                            input logic rv, input logic [31:0] rpc);
    bit was_full;
    bit popped;
    if (!r) begin
      m_pc = RESET_PC;
      m_q.delete();
      m_known = 1'b1;
    end else if (rv) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      was_full = (m_q.size() == DEPTH);
      popped   = (m_q.size() != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (en && (!was_full || popped)) begin
        m_q.push_back({m_pc, m_pc ^ IMEM_KEY});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Driver: check state left by the previous edge, apply inputs, advance one edge.
  task automatic cycle(input logic r, input logic en, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    if (m_known) check_outputs();
    rst                = r;
    bus.fetch_en       = en;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    model_step(r, en, rdy, rv, rpc);
    @(posedge clk);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_known = 1'b0;
    m_pc    = RESET_PC;
    rst                = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset, then steady fetch-and-drain.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Back-pressure to full, one pop-with-push, then drop one entry.
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect flush with decode trying to pop.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect near the top of the address space, then wrap.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Back-to-back redirects.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1001);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2003);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // fetch_en gating: drain, redirect while gated, then resume.
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400);
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset mid-stream with redirect and ready asserted.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0800);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_r, r_en, r_rdy, r_rv;
      logic [31:0] r_pc;
      r_r   = ($urandom_range(0, 199) != 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_rv  = ($urandom_range(0, 15) == 0);
      r_pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      cycle(r_r, r_en, r_rdy, r_rv, r_pc);
    end

    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch_queue.md
Name: ifetch_prefetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the core's decode stage and drives the combinational instruction memory.
- Walks the PC sequentially and captures {pc, instruction} pairs into a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- On a redirect from the core's branch/jump resolution, flushes the queue and restarts fetch at the redirect target.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, value driven on out_inst while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_en  in  1  permits fetch; 0 freezes fetch_pc and stops pushes. Pops still occur.
- imem_addr  out  32  instruction address to memory, = fetch_pc (combinational).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  32  PC of head entry.
- out_inst  out  32  instruction of head entry.
- redirect_valid  in  1  flush-and-restart request, one cycle.
- redirect_pc  in  32  restart address.
- q_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset, sampled at posedge with rst==0:
  - fetch_pc=RESET_PC, q_count=0, read/write pointers=0.
  - out_valid=0, out_pc=0, out_inst=NOP_INST, imem_addr=RESET_PC.
- State: fetch_pc register; circular buffer of DEPTH {pc,inst} entries; wr_ptr, rd_ptr, q_count.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (q_count<DEPTH | pop).
  - A push is allowed when the queue is full if a pop happens in the same cycle.
- On push:
  - entry[wr_ptr] <= {fetch_pc, imem_data}; wr_ptr++.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Latency: an instruction fetched at edge N appears on out_* after edge N, i.e. one cycle from imem_addr to out_valid.
- Occupancy update: q_count <= q_count + push − pop.
  - Simultaneous push and pop leaves q_count unchanged.
  - When empty, out_valid=0, so pop cannot occur.
- Outputs:
  - out_valid = (q_count!=0).
  - out_pc/out_inst = entry[rd_ptr] when valid; otherwise 0 and NOP_INST.
  - Outputs are registered state, never combinational from imem_data.
- Redirect (redirect_valid=1 at an edge) has priority over push and pop:
  - q_count<=0, rd_ptr<=wr_ptr.
  - fetch_pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are dropped.
  - No push that cycle.
  - A pop asserted by decode in that cycle is discarded; the head is lost with the flush.
  - Fetch resumes from the new PC on the next cycle.
- Back-to-back redirects: the last one wins; the queue stays empty.
- fetch_en=0:
  - fetch_pc holds and no push occurs; the queue drains through pops.
  - Redirect still updates fetch_pc.
- Reset mid-operation: all state returns to reset values in the same edge, regardless of redirect_valid or out_ready.
- Pointers wrap modulo DEPTH.

Test Plan:
1. Reset, then fetch and drain. Stimulus: rst low 2 cycles then high; fetch_en=1; out_ready=1; imem model returns inst = addr ^ 32'hA5A5_0000. Required: out_valid rises one cycle after reset release; out_pc sequence 0x0,0x4,0x8,…; out_inst for 0x8 is 32'hA5A5_0008; q_count stays at 1.
2. Back-pressure and full. Stimulus: out_ready=0 for 8 cycles. Required: q_count saturates at 4; fetch_pc holds at 0x10 and imem_addr=0x10 while full. Then out_ready=1 for one cycle: out_pc 0x0 pops and 0x10 is pushed in the same edge; q_count stays 4.
3. Redirect flush. Stimulus: with q_count=3, pulse redirect_valid with redirect_pc=0x200 while out_ready=1. Required: next cycle q_count=0, out_valid=0, out_inst=0x0000_0013, imem_addr=0x200; the cycle after, out_pc=0x200.
4. Misaligned redirect and wrap-around. Stimulus: redirect_pc=0xFFFF_FFFE. Required: first out_pc=0xFFFF_FFFC, next out_pc=0x0000_0000.
5. fetch_en gating. Stimulus: fetch_en=0 with q_count=2 and out_ready=1. Required: two pops occur, then out_valid=0; imem_addr is constant throughout. Re-enabling fetch_en resumes at the held PC with no gap or duplicate.
6. Reset mid-stream. Stimulus: rst=0 while q_count=3 and redirect_valid=1. Required: next cycle q_count=0, imem_addr=RESET_PC, out_pc=0.
